prio_encoder_rr: RTL
====================

# prio_encoder_rr

Parametrised N-to-log2(N) priority encoder with a registered output stage, a valid/ready handshake and a selectable round-robin mode. It is the next generation of the team's 4x2 enabled encoder and keeps that block's enable and valid semantics. It sits between request sources (interrupt lines, channel requests) and a downstream consumer that may stall. Results are held until the consumer accepts them.

## Interface
- N, default 8: number of request inputs; N >= 2, any value (not restricted to powers of two).
- W, default $clog2(N): width of the encoded index output.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  capture enable. When low, no new request is captured.
- mode  in  1  0 = fixed priority (highest index wins), 1 = round-robin.
- req  in  N  request vector, level-sensitive.
- ready  in  1  consumer accepts the held result this cycle.
- y  out  W  encoded index of the selected request.
- valid  out  1  y/multi hold an unaccepted result.
- multi  out  1  more than one req bit was set at capture.

## Operation
- Output stage state machine:
  - EMPTY: valid=0.
  - FULL: valid=1.
- Load condition: load = en && (req != 0) && (!valid || ready).
- On load:
  - y <= selected index.
  - multi <= (popcount(req) > 1).
  - State goes to FULL.
- FULL with ready=1 and no load: go to EMPTY; y and multi keep their last values.
- FULL with ready=0: y, valid and multi are frozen. req changes are ignored.
- Fixed mode: select the highest set index. With N=4, req=4'b1000 gives y=3, matching the 4x2 encoder.
- Round-robin mode:
  - Scan upward from pointer ptr, wrapping N-1 -> 0; the first set bit wins.
  - On load, ptr <= (k+1) mod N, where k is the selected index. Wrap is at N-1 for non-power-of-2 N.
- Fixed-mode loads leave ptr unchanged.
- mode is sampled only on load. Changing mode while FULL does not alter the held y.
- req=0 or en=0 never produces a result. The held result still drains on ready; en gates capture only.

## Timing
- Latency: 1 cycle. req is sampled at the rising edge where load=1; y/valid/multi are visible after that edge.
- Throughput: one result per cycle while ready=1 and requests are present. Back-to-back load on the same edge as acceptance (valid=1, ready=1, load=1) keeps valid=1 with the new y.
- ready while valid=0 has no effect.
- Reset values (asynchronous, immediate on rst_n low):
  - y=0, valid=0, multi=0.
  - ptr=0, state=EMPTY.
- Reset mid-transfer discards the held result. The first edge after rst_n rises may load.
- Simultaneous requests: resolved by the mode rules in Operation; multi=1 flags the contention.

## Structure
- Package prio_enc_pkg holds:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - The state enum {ST_EMPTY, ST_FULL}.
- Sub-module prio_pick is combinational: inputs req, ptr, mode; outputs idx, any, multi. Round-robin is implemented as a rotate, highest/lowest scan, and un-rotate.
- Top level holds only the state register, the ptr register and the output registers.

## Test plan
- Reset with no requests (rst_n low, then high; req=0, en=1) -> valid=0, y=0 for all cycles.
- Fixed mode, N=4, en=1, ready=1, req stepped 0001/0010/0100/1000 -> y=0/1/2/3, each 1 cycle later, multi=0, valid=1 each cycle. req=1011 -> y=3, multi=1.
- Enable low, en=0, req=0100 -> valid stays 0. Raise en -> y=2, valid=1 after one edge.
- Backpressure: capture req=8'h10 (y=4), hold ready=0 and change req=8'h80 for 5 cycles -> y=4 and valid=1 throughout. ready=1 -> next result y=7.
- Round-robin, N=8, req=8'hFF constant, ready=1 -> y cycles 0,1,…,7,0. N=5, req=5'b11111 -> y 0..4, then wraps to 0.
- Reset mid-operation: valid=1 and ready=0, assert rst_n low asynchronously between edges -> valid=0, y=0 immediately. The next round-robin grant starts from index 0.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared types and constants for the round-robin capable priority encoder.
package prio_enc_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/prio_pick.sv
// Combinational request picker: fixed highest-index priority, or round-robin
// via rotate-by-ptr, lowest-set scan, then un-rotate back to a request index.
module prio_pick
   import prio_enc_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   input  logic         mode,
   output logic [W-1:0] idx,
   output logic         any,
   output logic         multi
);

   logic [N-1:0] w_rot;
   logic [W-1:0] w_fix_idx;
   logic [W-1:0] w_rr_off;
   logic [W:0]   w_sum;

   // Doubling the vector makes the rotate correct for non-power-of-two N.
   assign w_rot = N'({req, req} >> ptr);

   always_comb begin
      w_fix_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (req[i]) w_fix_idx = W'(i);
      end
   end

   always_comb begin
      w_rr_off = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (w_rot[i]) w_rr_off = W'(i);
      end
   end

   always_comb begin
      w_sum = {1'b0, w_rr_off} + {1'b0, ptr};
      if (w_sum >= (W+1)'(N)) w_sum = w_sum - (W+1)'(N);
   end

   assign idx   = (mode == MODE_RR) ? w_sum[W-1:0] : w_fix_idx;
   assign any   = |req;
   assign multi = |(req & (req - N'(1)));

endmodule

// File: rtl/prio_encoder_rr.sv
// N-to-log2(N) priority encoder with a held output stage, valid/ready
// handshake and a selectable round-robin mode.
module prio_encoder_rr
   import prio_enc_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         mode,
   input  logic [N-1:0] req,
   input  logic         ready,
   output logic [W-1:0] y,
   output logic         valid,
   output logic         multi
);

   state_t       r_state;
   state_t       w_state_nxt;
   logic [W-1:0] r_ptr;
   logic [W-1:0] r_y;
   logic         r_multi;
   logic [W-1:0] w_idx;
   logic [W-1:0] w_ptr_inc;
   logic         w_any;
   logic         w_multi;
   logic         w_load;

   prio_pick #(.N(N), .W(W)) u_pick (
      .req   (req),
      .ptr   (r_ptr),
      .mode  (mode),
      .idx   (w_idx),
      .any   (w_any),
      .multi (w_multi)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_EMPTY;
      else        r_state <= w_state_nxt;
   end

   // A new capture may overlap acceptance of the held result.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = en && w_any && ((r_state == ST_EMPTY) || ready);
      case (r_state)
         ST_EMPTY: if (w_load) w_state_nxt = ST_FULL;
         ST_FULL: begin
            if (w_load)     w_state_nxt = ST_FULL;
            else if (ready) w_state_nxt = ST_EMPTY;
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   assign w_ptr_inc = (w_idx == W'(N - 1)) ? '0 : w_idx + W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y     <= '0;
         r_multi <= 1'b0;
         r_ptr   <= '0;
      end else if (w_load) begin
         r_y     <= w_idx;
         r_multi <= w_multi;
         if (mode == MODE_RR) r_ptr <= w_ptr_inc;
      end
   end

   assign y     = r_y;
   assign multi = r_multi;
   assign valid = (r_state == ST_FULL);

endmodule
